// File: rtl/sort_pkg.sv
// sort_pkg: shared sizing, pad value and packed-slot layout helpers for the sorter path.
package sort_pkg;
  localparam int DIM_DEF = 4;
  localparam int WIDTH_DEF = 8;
  // Returns w ones in the low bits; callers cast the result to their element width.
  function automatic logic [63:0] pad_val(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/frame_buf.sv
// frame_buf: one frame buffer with slot write, pad-on-close and element count.
module frame_buf
  import sort_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w(DIM),
  parameter int FILL_W = $clog2(DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic                 close,
  input  logic [FILL_W-1:0]    idx,
  input  logic [WIDTH-1:0]     din,
  output logic [DIM*WIDTH-1:0] data,
  output logic [CNT_W-1:0]     count
);
  localparam logic [WIDTH-1:0] PAD = WIDTH'(pad_val(WIDTH));
  logic [WIDTH-1:0] slot [DIM];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIM; k++) slot[k] <= '0;
      count <= '0;
    end else if (wr) begin
      for (int k = 0; k < DIM; k++)
        if (k == int'(idx)) slot[k] <= din;
        else if (close && k > int'(idx)) slot[k] <= PAD;
      if (close) count <= CNT_W'(idx) + CNT_W'(1);
    end
  end
  for (genvar k = 0; k < DIM; k++) begin : g_pack
    assign data[slot_lo(k, WIDTH) +: WIDTH] = slot[k];
  end
endmodule

// File: rtl/sort_frame_packer.sv
// sort_frame_packer: serial element stream to padded, packed frames via a ping-pong buffer pair.
module sort_frame_packer
  import sort_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w(DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DIM*WIDTH-1:0] frame_data,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 frame_valid,
  input  logic                 frame_ready
);
  localparam int FILL_W = $clog2(DIM);
  logic wp, rp, acc, close, pop;
  logic [FILL_W-1:0] fill;
  logic [1:0] occ;
  logic [DIM*WIDTH-1:0] d0, d1;
  logic [CNT_W-1:0] c0, c1;
  // Ready depends only on registered occupancy, so there is no path from frame_ready.
  assign in_ready = occ != 2'd2;
  assign frame_valid = occ != 2'd0;
  assign acc = in_valid && in_ready;
  assign close = acc && (in_last || fill == FILL_W'(DIM - 1));
  assign pop = frame_valid && frame_ready;
  assign frame_data = rp ? d1 : d0;
  assign frame_count = rp ? c1 : c0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
      fill <= '0;
      occ <= '0;
    end else begin
      if (acc) fill <= close ? '0 : fill + FILL_W'(1);
      if (close) wp <= !wp;
      if (pop) rp <= !rp;
      occ <= occ + 2'(close) - 2'(pop);
    end
  end
  frame_buf #(.DIM(DIM), .WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf0 (
    .clk(clk), .rst_n(rst_n), .wr(acc && !wp), .close(close), .idx(fill),
    .din(in_data), .data(d0), .count(c0)
  );
  frame_buf #(.DIM(DIM), .WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf1 (
    .clk(clk), .rst_n(rst_n), .wr(acc && wp), .close(close), .idx(fill),
    .din(in_data), .data(d1), .count(c1)
  );
endmodule

// File: tb/tb_sort_frame_packer.sv
// tb_sort_frame_packer: directed vectors with hand-computed frames for sort_frame_packer.
module tb_sort_frame_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [31:0] frame_data;
  logic [2:0] frame_count;
  logic frame_valid;
  logic frame_ready = 1'b0;
  int errors = 0;
  int checks = 0;
  sort_frame_packer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .frame_data(frame_data), .frame_count(frame_count),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_data", frame_data, 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    // single full frame
    frame_ready = 1'b1;
    beat(8'd7, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd9, 1'b0);
    chk("full_partial_hidden", 32'(frame_valid), 32'd0);
    beat(8'd1, 1'b0);
    chk("full_valid", 32'(frame_valid), 32'd1);
    chk("full_data", frame_data, 32'h01090307);
    chk("full_count", 32'(frame_count), 32'd4);
    tick();
    chk("full_single_pop", 32'(frame_valid), 32'd0);
    frame_ready = 1'b0;
    // short frame
    beat(8'd5, 1'b0);
    chk("short_hidden", 32'(frame_valid), 32'd0);
    beat(8'd2, 1'b1);
    chk("short_valid", 32'(frame_valid), 32'd1);
    chk("short_data", frame_data, 32'hFFFF0205);
    chk("short_count", 32'(frame_count), 32'd2);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("short_popped", 32'(frame_valid), 32'd0);
    // backpressure: three frames with consumer stalled
    for (int f = 1; f <= 2; f++)
      for (int i = 0; i < 4; i++) beat(8'(f * 16 + i), 1'b0);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_f1", frame_data, 32'h13121110);
    in_valid = 1'b1;
    in_data = 8'h30;
    tick();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_hold", frame_data, 32'h13121110);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_f2", frame_data, 32'h23222120);
    for (int i = 0; i < 4; i++) beat(8'(8'h30 + i), 1'b0);
    chk("bp_full_again", 32'(in_ready), 32'd0);
    chk("bp_f2_held", frame_data, 32'h23222120);
    frame_ready = 1'b1;
    tick();
    chk("bp_f3", frame_data, 32'h33323130);
    chk("bp_f3_count", 32'(frame_count), 32'd4);
    tick();
    frame_ready = 1'b0;
    chk("bp_drained", 32'(frame_valid), 32'd0);
    // close and pop in the same cycle
    for (int i = 1; i <= 7; i++) beat(8'(i), 1'b0);
    chk("cp_a_offered", frame_data, 32'h04030201);
    in_valid = 1'b1;
    in_data = 8'd8;
    frame_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    frame_ready = 1'b0;
    chk("cp_valid", 32'(frame_valid), 32'd1);
    chk("cp_b_data", frame_data, 32'h08070605);
    chk("cp_ready", 32'(in_ready), 32'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("cp_drained", 32'(frame_valid), 32'd0);
    // one-element frame carrying the pad value
    beat(8'hFF, 1'b1);
    chk("edge_data", frame_data, 32'hFFFFFFFF);
    chk("edge_count", 32'(frame_count), 32'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    // asynchronous reset with one frame held and one partial
    beat(8'h44, 1'b1);
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    chk("pre_rst_valid", 32'(frame_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_data", frame_data, 32'd0);
    chk("arst_count", 32'(frame_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    tick();
    chk("arst_hold_valid", 32'(frame_valid), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    beat(8'd9, 1'b0);
    beat(8'd8, 1'b0);
    beat(8'd7, 1'b0);
    beat(8'd6, 1'b0);
    chk("post_rst_data", frame_data, 32'h06070809);
    chk("post_rst_count", 32'(frame_count), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
